// File: rtl/ldst_queue.sv
// ldst_queue: 8-entry load/store queue between a core and a cache subsystem.
// Requests are accepted in program order, issued to the cache in order,
// answered by the cache in any order (loads only), and retired in order.
//
// Ports
//   clk, reset                       clock, synchronous active-high reset
//   core_addr_i/data_i/rw_i/valid_i  core request (rw: 1 = store, 0 = load)
//   core_stall_o                     queue full, request not accepted
//   core_data_o, core_ready_o        in-order load result, one-cycle pulse
//   addr_o/data_o/rw_o/valid_o/id_o  request to cache, id = queue slot
//   cache_data_i/id_i/ready_i        load data returned by cache
//   cache_stall_i                    cache cannot accept a request
//   err_o                            sticky: response to a slot not awaiting data
module ldst_queue #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] core_addr_i,
  input  logic [DATA_W-1:0] core_data_i,
  input  logic              core_rw_i,
  input  logic              core_valid_i,
  output logic              core_stall_o,
  output logic [DATA_W-1:0] core_data_o,
  output logic              core_ready_o,
  output logic [ADDR_W-1:0] addr_o,
  output logic [DATA_W-1:0] data_o,
  output logic              rw_o,
  output logic              valid_o,
  output logic [2:0]        id_o,
  input  logic [DATA_W-1:0] cache_data_i,
  input  logic [2:0]        cache_id_i,
  input  logic              cache_ready_i,
  input  logic              cache_stall_i,
  output logic              err_o
);

  // Slot states
  //   state         | meaning
  //   ST_FREE       | slot empty
  //   ST_WAIT_ISSUE | accepted from core, not yet taken by the cache
  //   ST_WAIT_DATA  | load issued, waiting for cache response
  //   ST_DONE       | complete, waiting to retire in order
  localparam int         DEPTH         = 8;
  localparam logic [1:0] ST_FREE       = 2'd0;
  localparam logic [1:0] ST_WAIT_ISSUE = 2'd1;
  localparam logic [1:0] ST_WAIT_DATA  = 2'd2;
  localparam logic [1:0] ST_DONE       = 2'd3;

  logic [1:0]        state_q [DEPTH];
  logic [1:0]        state_d [DEPTH];
  logic [ADDR_W-1:0] addr_q  [DEPTH];
  logic [ADDR_W-1:0] addr_d  [DEPTH];
  logic [DATA_W-1:0] data_q  [DEPTH];
  logic [DATA_W-1:0] data_d  [DEPTH];
  logic              rw_q    [DEPTH];
  logic              rw_d    [DEPTH];

  logic [2:0]        head_q, head_d;
  logic [2:0]        iss_q, iss_d;
  logic [2:0]        tail_q, tail_d;
  logic [3:0]        count_q, count_d;
  logic              core_ready_q, core_ready_d;
  logic [DATA_W-1:0] core_data_q, core_data_d;
  logic              err_q, err_d;

  logic enq, issue, resp_hit, resp_bad, retire;

  assign core_stall_o = (count_q == 4'd8);
  assign valid_o      = (state_q[iss_q] == ST_WAIT_ISSUE);
  assign addr_o       = addr_q[iss_q];
  assign data_o       = data_q[iss_q];
  assign rw_o         = rw_q[iss_q];
  assign id_o         = iss_q;
  assign core_ready_o = core_ready_q;
  assign core_data_o  = core_data_q;
  assign err_o        = err_q;

  // The four actions each target a slot in a different state (tail is FREE,
  // iss is WAIT_ISSUE, a valid response hits WAIT_DATA, head is DONE), so
  // they never collide on one slot and can all apply in the same cycle.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      state_d[i] = state_q[i];
      addr_d[i]  = addr_q[i];
      data_d[i]  = data_q[i];
      rw_d[i]    = rw_q[i];
    end
    head_d       = head_q;
    iss_d        = iss_q;
    tail_d       = tail_q;
    core_ready_d = 1'b0;
    core_data_d  = core_data_q;

    enq      = core_valid_i && !core_stall_o;
    issue    = (state_q[iss_q] == ST_WAIT_ISSUE) && !cache_stall_i;
    resp_hit = cache_ready_i && (state_q[cache_id_i] == ST_WAIT_DATA);
    resp_bad = cache_ready_i && (state_q[cache_id_i] != ST_WAIT_DATA);
    retire   = (state_q[head_q] == ST_DONE);

    if (enq) begin
      state_d[tail_q] = ST_WAIT_ISSUE;
      addr_d[tail_q]  = core_addr_i;
      data_d[tail_q]  = core_data_i;
      rw_d[tail_q]    = core_rw_i;
      tail_d          = tail_q + 3'd1;
    end

    // Stores need no response, so they complete as soon as the cache takes them.
    if (issue) begin
      state_d[iss_q] = rw_q[iss_q] ? ST_DONE : ST_WAIT_DATA;
      iss_d          = iss_q + 3'd1;
    end

    if (resp_hit) begin
      state_d[cache_id_i] = ST_DONE;
      data_d[cache_id_i]  = cache_data_i;
    end

    if (retire) begin
      state_d[head_q] = ST_FREE;
      head_d          = head_q + 3'd1;
      if (!rw_q[head_q]) begin
        core_ready_d = 1'b1;
        core_data_d  = data_q[head_q];
      end
    end

    count_d = count_q + {3'b000, enq} - {3'b000, retire};
    err_d   = err_q | resp_bad;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        state_q[i] <= ST_FREE;
        addr_q[i]  <= '0;
        data_q[i]  <= '0;
        rw_q[i]    <= 1'b0;
      end
      head_q       <= 3'd0;
      iss_q        <= 3'd0;
      tail_q       <= 3'd0;
      count_q      <= 4'd0;
      core_ready_q <= 1'b0;
      core_data_q  <= '0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      data_q       <= data_d;
      rw_q         <= rw_d;
      head_q       <= head_d;
      iss_q        <= iss_d;
      tail_q       <= tail_d;
      count_q      <= count_d;
      core_ready_q <= core_ready_d;
      core_data_q  <= core_data_d;
      err_q        <= err_d;
    end
  end

endmodule

// File: tb/tb_ldst_queue.sv
// tb_ldst_queue: scoreboard bench for ldst_queue.
// The stimulus process records every accepted request in program order; a
// monitor checks cache issues against that order and core_ready pulses
// against the in-order list of load results chosen by the bench's cache model.
module tb_ldst_queue;
  localparam int AW = 32;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          reset;
  logic [AW-1:0] core_addr_i;
  logic [DW-1:0] core_data_i;
  logic          core_rw_i;
  logic          core_valid_i;
  logic          core_stall_o;
  logic [DW-1:0] core_data_o;
  logic          core_ready_o;
  logic [AW-1:0] addr_o;
  logic [DW-1:0] data_o;
  logic          rw_o;
  logic          valid_o;
  logic [2:0]    id_o;
  logic [DW-1:0] cache_data_i;
  logic [2:0]    cache_id_i;
  logic          cache_ready_i;
  logic          cache_stall_i;
  logic          err_o;

  ldst_queue #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk(clk), .reset(reset),
    .core_addr_i(core_addr_i), .core_data_i(core_data_i), .core_rw_i(core_rw_i),
    .core_valid_i(core_valid_i), .core_stall_o(core_stall_o),
    .core_data_o(core_data_o), .core_ready_o(core_ready_o),
    .addr_o(addr_o), .data_o(data_o), .rw_o(rw_o), .valid_o(valid_o), .id_o(id_o),
    .cache_data_i(cache_data_i), .cache_id_i(cache_id_i),
    .cache_ready_i(cache_ready_i), .cache_stall_i(cache_stall_i), .err_o(err_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]    id;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    logic          rw;
    logic [DW-1:0] ret;
  } req_t;

  req_t          iss_exp[$];
  logic [DW-1:0] ret_exp[$];
  logic [2:0]    pend_id[$];
  logic [DW-1:0] pend_val[8];
  logic [2:0]    tail_id;
  int            tests = 0;
  int            fails = 0;
  int            ready_cnt = 0;
  bit            auto_resp = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: issue order and in-order load results.
  always @(negedge clk) begin
    req_t e;
    if (!reset) begin
      if (valid_o && !cache_stall_i) begin
        chk("issue_expected", 64'(iss_exp.size() != 0), 1);
        if (iss_exp.size() != 0) begin
          e = iss_exp.pop_front();
          chk("issue_id", id_o, e.id);
          chk("issue_addr", addr_o, e.addr);
          chk("issue_rw", rw_o, e.rw);
          if (e.rw) chk("issue_data", data_o, e.data);
          else begin
            pend_id.push_back(e.id);
            pend_val[e.id] = e.ret;
          end
        end
      end
      if (core_ready_o) begin
        ready_cnt++;
        chk("ready_expected", 64'(ret_exp.size() != 0), 1);
        if (ret_exp.size() != 0) chk("core_data", core_data_o, ret_exp.pop_front());
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    core_valid_i = 0; core_rw_i = 0; core_addr_i = '0; core_data_i = '0;
    cache_ready_i = 0; cache_id_i = '0; cache_data_i = '0; cache_stall_i = 0;
  endtask

  task automatic do_reset();
    reset = 1;
    idle();
    iss_exp.delete(); ret_exp.delete(); pend_id.delete();
    tail_id = 3'd0;
    cyc();
    reset = 0;
  endtask

  // Present a request this cycle; it is accepted at the next edge unless stalled.
  task automatic offer(input logic rw, input logic [AW-1:0] a, input logic [DW-1:0] d,
                       input logic [DW-1:0] ret);
    req_t r;
    core_valid_i = 1; core_rw_i = rw; core_addr_i = a; core_data_i = d;
    if (!core_stall_o) begin
      r.id = tail_id; r.addr = a; r.data = d; r.rw = rw; r.ret = ret;
      iss_exp.push_back(r);
      if (!rw) ret_exp.push_back(ret);
      tail_id = tail_id + 3'd1;
    end
  endtask

  task automatic resp(input logic [2:0] id, input logic [DW-1:0] d);
    int k;
    cache_ready_i = 1; cache_id_i = id; cache_data_i = d;
    k = -1;
    for (int i = 0; i < pend_id.size(); i++) if (pend_id[i] == id && k < 0) k = i;
    if (k >= 0) pend_id.delete(k);
  endtask

  // Cache model: answer a random outstanding load, in any order.
  task automatic auto_step();
    int k;
    cache_ready_i = 0;
    if (auto_resp && pend_id.size() > 0 && $urandom_range(1, 0) == 1) begin
      k = $urandom_range(pend_id.size() - 1, 0);
      cache_ready_i = 1;
      cache_id_i    = pend_id[k];
      cache_data_i  = pend_val[pend_id[k]];
      pend_id.delete(k);
    end
  endtask

  task automatic drain(input int budget);
    int n;
    n = 0;
    core_valid_i = 0; cache_stall_i = 0; auto_resp = 1;
    while ((iss_exp.size() != 0 || ret_exp.size() != 0 || pend_id.size() != 0) && n < budget) begin
      auto_step();
      cyc();
      n++;
    end
    cache_ready_i = 0;
    auto_resp = 0;
    repeat (4) cyc();
    chk("drain_in_budget", 64'(n < budget), 1);
  endtask

  task automatic check_all_zero(input string p);
    chk({p, "_stall"}, core_stall_o, 0);
    chk({p, "_ready"}, core_ready_o, 0);
    chk({p, "_cdata"}, core_data_o, 0);
    chk({p, "_valid"}, valid_o, 0);
    chk({p, "_addr"}, addr_o, 0);
    chk({p, "_data"}, data_o, 0);
    chk({p, "_rw"}, rw_o, 0);
    chk({p, "_id"}, id_o, 0);
    chk({p, "_err"}, err_o, 0);
  endtask

  initial begin
    int rc0;
    reset = 1;
    idle();
    tail_id = 3'd0;
    cyc();
    do_reset();
    check_all_zero("reset");

    // Single load: issue one cycle after enqueue, ready two cycles after return.
    do_reset();
    offer(0, 97, 0, 32'h1234);
    chk("t036_valid_early", valid_o, 0);
    cyc();
    core_valid_i = 0;
    chk("t036_valid", valid_o, 1);
    chk("t036_id", id_o, 0);
    cyc();
    cyc();
    resp(0, 32'h1234);
    cyc();
    cache_ready_i = 0;
    chk("t036_ready_n1", core_ready_o, 0);
    cyc();
    chk("t036_ready_n2", core_ready_o, 1);
    chk("t036_data", core_data_o, 32'h1234);
    cyc();
    chk("t036_pulse_one", core_ready_o, 0);
    chk("t036_data_hold", core_data_o, 32'h1234);

    // Store then load: one ready pulse, store does not disturb core_data_o.
    do_reset();
    rc0 = ready_cnt;
    offer(1, 301, 16, 0); cyc();
    offer(0, 97, 0, 32'h5555); cyc();
    drain(200);
    chk("t037_ready_count", ready_cnt - rc0, 1);
    offer(1, 400, 77, 0); cyc();
    drain(200);
    chk("t037_store_hold", core_data_o, 32'h5555);
    chk("t037_ready_count2", ready_cnt - rc0, 1);

    // Out-of-order returns, in-order results.
    do_reset();
    rc0 = ready_cnt;
    offer(0, 10, 0, 32'hA); cyc();
    offer(0, 20, 0, 32'hB); cyc();
    core_valid_i = 0; cyc();
    resp(1, 32'hB); cyc();
    cache_ready_i = 0;
    chk("t038_wait_older", core_ready_o, 0);
    cyc();
    chk("t038_wait_older2", core_ready_o, 0);
    resp(0, 32'hA); cyc();
    cache_ready_i = 0;
    drain(100);
    chk("t038_ready_count", ready_cnt - rc0, 2);

    // Full queue under cache stall.
    do_reset();
    rc0 = ready_cnt;
    cache_stall_i = 1;
    for (int i = 0; i < 9; i++) begin
      chk("t039_stall", core_stall_o, (i == 8) ? 1 : 0);
      if (i > 0) begin
        chk("t039_valid", valid_o, 1);
        chk("t039_addr", addr_o, 100);
        chk("t039_id", id_o, 0);
      end
      offer((i % 2) == 1, 100 + i * 4, i, 32'hC000 + i);
      cyc();
    end
    core_valid_i = 0;
    cyc();
    chk("t039_stall_hold", core_stall_o, 1);
    chk("t039_addr_hold", addr_o, 100);
    drain(300);
    chk("t039_ready_count", ready_cnt - rc0, 4);
    chk("t039_unstall", core_stall_o, 0);

    // Response to a free slot: sticky error, no result.
    do_reset();
    resp(5, 32'hDEAD); cyc();
    cache_ready_i = 0;
    chk("t040_err", err_o, 1);
    cyc(); cyc();
    chk("t040_err_sticky", err_o, 1);
    chk("t040_no_ready", core_ready_o, 0);
    do_reset();
    chk("t040_err_cleared", err_o, 0);

    // Reset with entries outstanding discards them.
    do_reset();
    cache_stall_i = 1;
    for (int i = 0; i < 3; i++) begin
      offer(0, 200 + i, 0, 32'h77 + i);
      cyc();
    end
    core_valid_i = 0;
    do_reset();
    check_all_zero("t041");
    for (int i = 0; i < 3; i++) begin
      resp(i[2:0], 32'h77 + i);
      cyc();
    end
    cache_ready_i = 0;
    repeat (4) cyc();
    chk("t041_no_valid", valid_o, 0);
    chk("t041_err", err_o, 1);

    // Randomized traffic against the scoreboard.
    do_reset();
    auto_resp = 1;
    for (int c = 0; c < 1500; c++) begin
      cache_stall_i = ($urandom_range(9, 0) < 3);
      if ($urandom_range(1, 0) == 1)
        offer($urandom_range(1, 0) == 1, $urandom, $urandom, $urandom);
      else
        core_valid_i = 0;
      auto_step();
      cyc();
    end
    drain(500);
    chk("rand_err_clear", err_o, 0);
    chk("rand_empty_stall", core_stall_o, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, tests %0d", tests);
    $fatal(1, "timeout");
  end

endmodule
